// File: rtl/mon_pkg.sv
// Shared types and default constants for the store result monitor.
// Covers verdict states, the default pass/allow addresses and one logged store record.
package mon_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'b00,
        PASS = 2'b01,
        FAIL = 2'b10,
        TOUT = 2'b11
    } mon_state_t;

    localparam logic [31:0] DEF_PASS_ADDR      = 32'd84;
    localparam logic [31:0] DEF_PASS_DATA      = 32'd7;
    localparam logic [31:0] DEF_ALLOW_ADDR     = 32'd80;
    localparam int          DEF_TIMEOUT_CYCLES = 1000;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } store_rec_t;

endpackage

// File: rtl/store_log_ring.sv
// Ring log of the most recent stores.
// Read index 0 is the newest entry; indices at or past the valid count read as zero.
module store_log_ring
    import mon_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  store_rec_t               wr_rec,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output store_rec_t               rd_rec,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int IW = $clog2(DEPTH);

    store_rec_t      mem [DEPTH];
    logic [IW-1:0]   wr_ptr;
    logic [IW-1:0]   rd_ptr;

    // NOTE: the log storage is reset on purpose, because every entry must read as zero after rst.
    // This is not done only for tidiness.
    // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wr_ptr] <= wr_rec;
            wr_ptr      <= wr_ptr + IW'(1);
            if (count != (IW+1)'(DEPTH)) begin
                count <= count + (IW+1)'(1);
            end
        end
    end

    // DEPTH is a power of two, so pointer arithmetic wraps on its own
    assign rd_ptr = wr_ptr - IW'(1) - rd_idx;

    // NOTE: rd_rec gets a default before the conditional, so no latch is inferred.
    always_comb begin
        rd_rec = '0;
        if ({1'b0, rd_idx} < count) begin
            rd_rec = mem[rd_ptr];
        end
    end

endmodule

// File: rtl/store_result_monitor.sv
// Watches the CPU store bus and decides pass, fail or timeout for the self-check program.
// The verdicts are registered, and the monitor keeps a ring log of recent stores.
module store_result_monitor
    import mon_pkg::*;
#(
    parameter logic [31:0] PASS_ADDR      = DEF_PASS_ADDR,
    parameter logic [31:0] PASS_DATA      = DEF_PASS_DATA,
    parameter logic [31:0] ALLOW_ADDR     = DEF_ALLOW_ADDR,
    parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int          LOG_DEPTH      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         memwrite,
    input  logic [31:0]                  dataadr,
    input  logic [31:0]                  writedata,
    input  logic [31:0]                  pc,
    output logic                         pass,
    output logic                         fail,
    output logic                         timeout,
    output logic                         done,
    output logic [31:0]                  cycle_cnt,
    output logic [15:0]                  store_cnt,
    output logic [31:0]                  fail_addr,
    output logic [31:0]                  fail_data,
    output logic [31:0]                  fail_pc,
    input  logic [$clog2(LOG_DEPTH)-1:0] log_rd_idx,
    output logic [31:0]                  log_rd_addr,
    output logic [31:0]                  log_rd_data,
    output logic [$clog2(LOG_DEPTH):0]   log_count
);

    mon_state_t state;
    logic       run;
    logic       is_pass;
    logic       is_illegal;
    logic       at_limit;
    store_rec_t wr_rec;
    store_rec_t rd_rec;

    assign run        = (state == RUN);
    assign is_pass    = (dataadr == PASS_ADDR) && (writedata == PASS_DATA);
    assign is_illegal = (dataadr != ALLOW_ADDR);
    assign at_limit   = (cycle_cnt == 32'(TIMEOUT_CYCLES - 1));
    assign wr_rec     = '{addr: dataadr, data: writedata};

    // Stores are logged only while running, and the deciding store is included
    store_log_ring #(
        .DEPTH (LOG_DEPTH)
    ) u_log (
        .clk    (clk),
        .rst    (rst),
        .we     (run && memwrite),
        .wr_rec (wr_rec),
        .rd_idx (log_rd_idx),
        .rd_rec (rd_rec),
        .count  (log_count)
    );

    assign log_rd_addr = rd_rec.addr;
    assign log_rd_data = rd_rec.data;

    // Terminal states hold everything frozen until rst; a store verdict beats the watchdog
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            pass      <= 1'b0;
            fail      <= 1'b0;
            timeout   <= 1'b0;
            done      <= 1'b0;
            cycle_cnt <= '0;
            store_cnt <= '0;
            fail_addr <= '0;
            fail_data <= '0;
            fail_pc   <= '0;
        end else if (run) begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (memwrite && (store_cnt != 16'hFFFF)) begin
                store_cnt <= store_cnt + 16'd1;
            end
            if (memwrite && is_pass) begin
                state <= PASS;
                pass  <= 1'b1;
                done  <= 1'b1;
            end else if (memwrite && is_illegal) begin
                state     <= FAIL;
                fail      <= 1'b1;
                done      <= 1'b1;
                fail_addr <= dataadr;
                fail_data <= writedata;
                fail_pc   <= pc;
            end else if (at_limit) begin
                state   <= TOUT;
                timeout <= 1'b1;
                done    <= 1'b1;
            end
        end
    end

endmodule
